// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM encodings, arbitration
// mode codes and default bus widths matching the memory controller.
package mem_port_arbiter_pkg;

  // Default widths, aligned with the controller's data, address and length buses
  localparam int unsigned C_DATA_L = 32;
  localparam int unsigned M_ADDR_L = 32;
  localparam int unsigned RW_LEN_L = 2;

  // Arbitration modes
  localparam int unsigned ArbRoundRobin = 0;
  localparam int unsigned ArbFixedPrio  = 1;

  // FSM state encodings
  localparam int unsigned StateW = 2;
  localparam logic [StateW-1:0] StIdle = 2'd0;
  localparam logic [StateW-1:0] StRd   = 2'd1;
  localparam logic [StateW-1:0] StWr   = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational request picker. Scans N requests starting at ptr_i (wrapping
// modulo N) in round-robin mode, or at channel 0 in fixed-priority mode.
module mem_port_arbiter_rr_pick #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  input  logic            fixed_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] start;
  logic [IdxW:0]   cand;
  logic            found;

  // First requesting channel at or after the start point wins
  always_comb begin
    start = fixed_i ? '0 : ptr_i;
    cand  = '0;
    found = 1'b0;
    idx_o = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, start} + (IdxW + 1)'(k);
      if (cand >= (IdxW + 1)'(N)) begin
        cand = cand - (IdxW + 1)'(N);
      end
      if (!found && req_i[cand[IdxW-1:0]]) begin
        found = 1'b1;
        idx_o = cand[IdxW-1:0];
      end
    end
    gnt_o = found ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-core memory arbiter: merges RPORT read ports and WPORT write ports onto the
// single controller channel, with selectable arbitration, a per-access
// timeout that aborts with an error pulse, and registered per-port read data.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned CORE     = 1,
  parameter int unsigned RPORT    = CORE * 2,
  parameter int unsigned WPORT    = CORE,
  parameter int unsigned DATA_W   = C_DATA_L,
  parameter int unsigned ADDR_W   = M_ADDR_L,
  parameter int unsigned LEN_W    = RW_LEN_L,
  parameter int unsigned ARB_MODE = ArbRoundRobin,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RPORT-1:0]        co_re,
  input  logic [RPORT*ADDR_W-1:0] co_raddr,
  input  logic [RPORT*LEN_W-1:0]  co_rlen,
  output logic [RPORT*DATA_W-1:0] co_din,
  output logic [RPORT-1:0]        co_rack,
  input  logic [WPORT-1:0]        co_we,
  input  logic [WPORT*ADDR_W-1:0] co_waddr,
  input  logic [WPORT*LEN_W-1:0]  co_wlen,
  input  logic [WPORT*DATA_W-1:0] co_dout,
  output logic [WPORT-1:0]        co_wack,
  output logic                    c_re,
  output logic                    c_we,
  output logic [ADDR_W-1:0]       read_addr,
  output logic [ADDR_W-1:0]       write_addr,
  output logic [LEN_W-1:0]        c_rlen,
  output logic [LEN_W-1:0]        c_wlen,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    m_rack,
  input  logic                    m_wack,
  output logic                    err_valid,
  output logic [7:0]              err_chan
);

  localparam int unsigned N      = RPORT + WPORT;
  localparam int unsigned IdxW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit          ToEn   = (TIMEOUT != 0);
  localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [StateW-1:0]       state_q, state_d;
  logic [IdxW-1:0]         chan_q, chan_d;
  logic [IdxW-1:0]         ptr_q, ptr_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    c_re_q, c_re_d;
  logic                    c_we_q, c_we_d;
  logic [ADDR_W-1:0]       read_addr_q, read_addr_d;
  logic [ADDR_W-1:0]       write_addr_q, write_addr_d;
  logic [LEN_W-1:0]        c_rlen_q, c_rlen_d;
  logic [LEN_W-1:0]        c_wlen_q, c_wlen_d;
  logic [DATA_W-1:0]       data_out_q, data_out_d;
  logic [RPORT*DATA_W-1:0] co_din_q, co_din_d;
  logic [RPORT-1:0]        co_rack_q, co_rack_d;
  logic [WPORT-1:0]        co_wack_q, co_wack_d;
  logic                    err_valid_q, err_valid_d;
  logic [7:0]              err_chan_q, err_chan_d;

  logic [N-1:0]    pick_gnt;
  logic [IdxW-1:0] pick_idx;
  logic            pick_is_rd;
  logic            ack_busy;
  logic            timeout_hit;
  logic [IdxW-1:0] next_ptr;

  mem_port_arbiter_rr_pick #(
    .N    (N),
    .IdxW (IdxW)
  ) u_pick (
    .req_i   ({co_we, co_re}),
    .ptr_i   (ptr_q),
    .fixed_i (ARB_MODE == ArbFixedPrio),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx)
  );

  assign pick_is_rd  = |pick_gnt[RPORT-1:0];
  // The finished requester still holds its request during its ack pulse, so
  // arbitration pauses for that cycle to avoid re-granting a stale request.
  assign ack_busy    = (|co_rack_q) | (|co_wack_q);
  assign timeout_hit = ToEn && (cnt_q == CntMax);
  assign next_ptr    = (chan_q == IdxW'(N - 1)) ? '0 : chan_q + IdxW'(1);

  // Arbitration, access tracking and completion / abort
  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    c_re_d       = c_re_q;
    c_we_d       = c_we_q;
    read_addr_d  = read_addr_q;
    write_addr_d = write_addr_q;
    c_rlen_d     = c_rlen_q;
    c_wlen_d     = c_wlen_q;
    data_out_d   = data_out_q;
    co_din_d     = co_din_q;
    co_rack_d    = '0;
    co_wack_d    = '0;
    err_valid_d  = 1'b0;
    err_chan_d   = err_chan_q;

    case (state_q)
      StIdle: begin
        if ((|pick_gnt) && !ack_busy) begin
          chan_d = pick_idx;
          cnt_d  = '0;
          if (pick_is_rd) begin
            state_d = StRd;
            c_re_d  = 1'b1;
            for (int i = 0; i < RPORT; i++) begin
              if (pick_idx == IdxW'(i)) begin
                read_addr_d = co_raddr[i*ADDR_W +: ADDR_W];
                c_rlen_d    = co_rlen[i*LEN_W +: LEN_W];
              end
            end
          end else begin
            state_d = StWr;
            c_we_d  = 1'b1;
            for (int j = 0; j < WPORT; j++) begin
              if (pick_idx == IdxW'(RPORT + j)) begin
                write_addr_d = co_waddr[j*ADDR_W +: ADDR_W];
                c_wlen_d     = co_wlen[j*LEN_W +: LEN_W];
                data_out_d   = co_dout[j*DATA_W +: DATA_W];
              end
            end
          end
        end
      end

      StRd: begin
        if (m_rack || timeout_hit) begin
          // Ack wins over a coincident timeout; an abort returns zero data
          for (int i = 0; i < RPORT; i++) begin
            if (chan_q == IdxW'(i)) begin
              co_din_d[i*DATA_W +: DATA_W] = m_rack ? data_in : '0;
              co_rack_d[i]                 = 1'b1;
            end
          end
          err_valid_d = !m_rack;
          if (!m_rack) err_chan_d = 8'(chan_q);
          c_re_d  = 1'b0;
          ptr_d   = next_ptr;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StWr: begin
        if (m_wack || timeout_hit) begin
          for (int j = 0; j < WPORT; j++) begin
            if (chan_q == IdxW'(RPORT + j)) co_wack_d[j] = 1'b1;
          end
          err_valid_d = !m_wack;
          if (!m_wack) err_chan_d = 8'(chan_q);
          c_we_d  = 1'b0;
          ptr_d   = next_ptr;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        c_re_d  = 1'b0;
        c_we_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      chan_q       <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      c_re_q       <= 1'b0;
      c_we_q       <= 1'b0;
      read_addr_q  <= '0;
      write_addr_q <= '0;
      c_rlen_q     <= '0;
      c_wlen_q     <= '0;
      data_out_q   <= '0;
      co_din_q     <= '0;
      co_rack_q    <= '0;
      co_wack_q    <= '0;
      err_valid_q  <= 1'b0;
      err_chan_q   <= '0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      c_re_q       <= c_re_d;
      c_we_q       <= c_we_d;
      read_addr_q  <= read_addr_d;
      write_addr_q <= write_addr_d;
      c_rlen_q     <= c_rlen_d;
      c_wlen_q     <= c_wlen_d;
      data_out_q   <= data_out_d;
      co_din_q     <= co_din_d;
      co_rack_q    <= co_rack_d;
      co_wack_q    <= co_wack_d;
      err_valid_q  <= err_valid_d;
      err_chan_q   <= err_chan_d;
    end
  end

  assign c_re       = c_re_q;
  assign c_we       = c_we_q;
  assign read_addr  = read_addr_q;
  assign write_addr = write_addr_q;
  assign c_rlen     = c_rlen_q;
  assign c_wlen     = c_wlen_q;
  assign data_out   = data_out_q;
  assign co_din     = co_din_q;
  assign co_rack    = co_rack_q;
  assign co_wack    = co_wack_q;
  assign err_valid  = err_valid_q;
  assign err_chan   = err_chan_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. dut_a: one core, round-robin,
// TIMEOUT=8. dut_b / dut_c: two cores sharing request inputs, round-robin
// and fixed priority respectively, with the timeout disabled.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut_a signals (RPORT=2, WPORT=1)
  logic [1:0]  a_re;
  logic [63:0] a_raddr;
  logic [3:0]  a_rlen;
  logic [63:0] a_din;
  logic [1:0]  a_rack;
  logic [0:0]  a_we;
  logic [31:0] a_waddr;
  logic [1:0]  a_wlen;
  logic [31:0] a_dout;
  logic [0:0]  a_wack;
  logic        a_c_re, a_c_we;
  logic [31:0] a_read_addr, a_write_addr, a_data_out;
  logic [1:0]  a_c_rlen, a_c_wlen;
  logic        a_m_rack, a_m_wack;
  logic        a_err_valid;
  logic [7:0]  a_err_chan;
  logic [31:0] data_in;

  // shared request side of dut_b / dut_c (RPORT=4, WPORT=2)
  logic [3:0]   bc_re;
  logic [127:0] bc_raddr;
  logic [7:0]   bc_rlen;
  logic [1:0]   bc_we;
  logic [63:0]  bc_waddr;
  logic [3:0]   bc_wlen;
  logic [63:0]  bc_dout;

  logic [127:0] b_din, c_din;
  logic [3:0]   b_rack, c_rack;
  logic [1:0]   b_wack, c_wack;
  logic         b_c_re, b_c_we, c_c_re, c_c_we;
  logic [31:0]  b_read_addr, b_write_addr, b_data_out;
  logic [31:0]  c_read_addr, c_write_addr, c_data_out;
  logic [1:0]   b_c_rlen, b_c_wlen, c_c_rlen, c_c_wlen;
  logic         b_m_rack, b_m_wack, c_m_rack, c_m_wack;
  logic         b_err_valid, c_err_valid;
  logic [7:0]   b_err_chan, c_err_chan;

  mem_port_arbiter #(.CORE(1), .ARB_MODE(0), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst),
    .co_re(a_re), .co_raddr(a_raddr), .co_rlen(a_rlen), .co_din(a_din), .co_rack(a_rack),
    .co_we(a_we), .co_waddr(a_waddr), .co_wlen(a_wlen), .co_dout(a_dout), .co_wack(a_wack),
    .c_re(a_c_re), .c_we(a_c_we), .read_addr(a_read_addr), .write_addr(a_write_addr),
    .c_rlen(a_c_rlen), .c_wlen(a_c_wlen), .data_out(a_data_out), .data_in(data_in),
    .m_rack(a_m_rack), .m_wack(a_m_wack), .err_valid(a_err_valid), .err_chan(a_err_chan)
  );

  mem_port_arbiter #(.CORE(2), .ARB_MODE(0), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst),
    .co_re(bc_re), .co_raddr(bc_raddr), .co_rlen(bc_rlen), .co_din(b_din), .co_rack(b_rack),
    .co_we(bc_we), .co_waddr(bc_waddr), .co_wlen(bc_wlen), .co_dout(bc_dout), .co_wack(b_wack),
    .c_re(b_c_re), .c_we(b_c_we), .read_addr(b_read_addr), .write_addr(b_write_addr),
    .c_rlen(b_c_rlen), .c_wlen(b_c_wlen), .data_out(b_data_out), .data_in(data_in),
    .m_rack(b_m_rack), .m_wack(b_m_wack), .err_valid(b_err_valid), .err_chan(b_err_chan)
  );

  mem_port_arbiter #(.CORE(2), .ARB_MODE(1), .TIMEOUT(0)) dut_c (
    .clk(clk), .rst(rst),
    .co_re(bc_re), .co_raddr(bc_raddr), .co_rlen(bc_rlen), .co_din(c_din), .co_rack(c_rack),
    .co_we(bc_we), .co_waddr(bc_waddr), .co_wlen(bc_wlen), .co_dout(bc_dout), .co_wack(c_wack),
    .c_re(c_c_re), .c_we(c_c_we), .read_addr(c_read_addr), .write_addr(c_write_addr),
    .c_rlen(c_c_rlen), .c_wlen(c_c_wlen), .data_out(c_data_out), .data_in(data_in),
    .m_rack(c_m_rack), .m_wack(c_m_wack), .err_valid(c_err_valid), .err_chan(c_err_chan)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Move to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hard stop in case something wedges
  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int          waited;
    logic [31:0] got;

    rst = 1'b1;
    a_re = '0; a_raddr = '0; a_rlen = '0; a_we = '0; a_waddr = '0; a_wlen = '0; a_dout = '0;
    a_m_rack = 1'b0; a_m_wack = 1'b0; data_in = '0;
    bc_re = '0; bc_raddr = '0; bc_rlen = '0; bc_we = '0; bc_waddr = '0; bc_wlen = '0;
    bc_dout = '0;
    b_m_rack = 1'b0; b_m_wack = 1'b0; c_m_rack = 1'b0; c_m_wack = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_c_re", a_c_re, 0);
    check("rst_c_we", a_c_we, 0);
    check("rst_co_din", a_din, 0);
    check("rst_err", {a_err_valid, a_err_chan}, 0);
    check("rst_acks", {a_rack, a_wack}, 0);

    // Single read on channel 1, controller acks three cycles after issue
    a_raddr[63:32] = 32'h100; a_rlen[3:2] = 2'd1; a_re = 2'b10;
    check("rd_c0_idle", a_c_re, 0);
    tick();
    check("rd_c1_c_re", a_c_re, 1);
    check("rd_c1_addr", a_read_addr, 32'h100);
    check("rd_c1_len", a_c_rlen, 2'd1);
    tick(); tick(); tick();
    check("rd_c4_c_re", a_c_re, 1);
    data_in = 32'hDEADBEEF; a_m_rack = 1'b1;
    tick();
    a_m_rack = 1'b0;
    check("rd_c5_rack", a_rack, 2'b10);
    check("rd_c5_din1", a_din[63:32], 32'hDEADBEEF);
    check("rd_c5_din0", a_din[31:0], 32'h0);
    check("rd_c5_c_re", a_c_re, 0);
    a_re = 2'b00;
    tick();
    check("rd_c6_rack", a_rack, 2'b00);

    // Write on channel 2 with a stray read ack during WR
    a_waddr = 32'h1000; a_dout = 32'h12345678; a_wlen = 2'd2; a_we = 1'b1;
    tick();
    check("wr_c_we", a_c_we, 1);
    check("wr_c_re", a_c_re, 0);
    check("wr_addr", a_write_addr, 32'h1000);
    check("wr_data", a_data_out, 32'h12345678);
    check("wr_len", a_c_wlen, 2'd2);
    a_m_rack = 1'b1; data_in = 32'hBAD0BAD0;
    tick();
    a_m_rack = 1'b0;
    check("wr_stray_c_we", a_c_we, 1);
    check("wr_stray_rack", a_rack, 2'b00);
    check("wr_stray_din", a_din, {32'hDEADBEEF, 32'h0});
    a_m_wack = 1'b1;
    tick();
    a_m_wack = 1'b0;
    check("wr_wack", a_wack, 1'b1);
    check("wr_c_we_drop", a_c_we, 0);
    a_we = 1'b0;
    tick();
    check("wr_wack_end", a_wack, 1'b0);

    // Read on channel 0, ack lands exactly on the timeout cycle
    a_raddr[31:0] = 32'h40; a_re = 2'b01;
    for (int i = 0; i < 8; i++) tick();
    check("tohit_c8_c_re", a_c_re, 1);
    data_in = 32'hCAFEF00D; a_m_rack = 1'b1;
    tick();
    a_m_rack = 1'b0;
    check("tohit_rack", a_rack, 2'b01);
    check("tohit_din0", a_din[31:0], 32'hCAFEF00D);
    check("tohit_err", a_err_valid, 0);
    a_re = 2'b00;
    tick();

    // Read on channel 0 with no ack: abort after 8 cycles
    a_re = 2'b01;
    for (int i = 0; i < 8; i++) tick();
    check("to_c8_c_re", a_c_re, 1);
    tick();
    check("to_c9_c_re", a_c_re, 0);
    check("to_rack", a_rack, 2'b01);
    check("to_din0", a_din[31:0], 32'h0);
    check("to_din1", a_din[63:32], 32'hDEADBEEF);
    check("to_err_valid", a_err_valid, 1);
    check("to_err_chan", a_err_chan, 8'd0);
    a_re = 2'b00;
    tick();
    check("to_err_end", a_err_valid, 0);

    // Reset while in RD (pointer is 1 here)
    a_re = 2'b10;
    tick();
    check("rstrd_c_re", a_c_re, 1);
    tick();
    rst = 1'b1;
    tick();
    check("rstrd_drop", a_c_re, 0);
    check("rstrd_no_ack", a_rack, 2'b00);
    check("rstrd_din", a_din, 0);
    rst = 1'b0; a_re = 2'b11;
    tick();
    check("rstrd_ptr0_c_re", a_c_re, 1);
    check("rstrd_ptr0_addr", a_read_addr, 32'h40);
    a_m_rack = 1'b1; data_in = 32'h0;
    tick();
    a_m_rack = 1'b0; a_re = 2'b00;
    tick();

    // Two cores, all six channels requesting
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) bc_raddr[i*32 +: 32] = 32'h100 + 32'(i);
    for (int j = 0; j < 2; j++) bc_waddr[j*32 +: 32] = 32'h200 + 32'(j);
    bc_re = 4'hF; bc_we = 2'b11;

    // Round-robin: 0,1,2,3,4,5,0
    for (int k = 0; k < 7; k++) begin
      waited = 0;
      while (!(b_c_re || b_c_we) && waited < 10) begin
        tick();
        waited++;
      end
      check("rr_wait", waited < 10, 1);
      got = b_c_re ? (b_read_addr - 32'h100) : (b_write_addr - 32'h200 + 32'd4);
      check($sformatf("rr_grant%0d", k), got, 32'(k % 6));
      if (b_c_re) b_m_rack = 1'b1;
      else b_m_wack = 1'b1;
      tick();
      b_m_rack = 1'b0; b_m_wack = 1'b0;
    end

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Fixed priority: channel 0 keeps winning; once it drops, channel 1
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bc_re = 4'hE;
      waited = 0;
      while (!(c_c_re || c_c_we) && waited < 10) begin
        tick();
        waited++;
      end
      check("fp_wait", waited < 10, 1);
      got = c_c_re ? (c_read_addr - 32'h100) : (c_write_addr - 32'h200 + 32'd4);
      check($sformatf("fp_grant%0d", k), got, (k == 3) ? 32'd1 : 32'd0);
      if (c_c_re) c_m_rack = 1'b1;
      else c_m_wack = 1'b1;
      tick();
      c_m_rack = 1'b0; c_m_wack = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
